// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: instruction-memory request/response, decode handoff and branch redirect.
// master = fetch stage, slave = memory/decode/execute side.
interface instr_fetch_if #(
  parameter int PC_W = 8
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_rdata;
  logic            imem_ack;
  logic [15:0]     instruction;
  logic            instr_valid;
  logic            instr_ready;
  logic [PC_W-1:0] pc_out;
  logic            branch_taken;
  logic [PC_W-1:0] branch_target;
  logic            halted;

  modport master (
    output imem_req, imem_addr, instruction, instr_valid, pc_out, halted,
    input  imem_rdata, imem_ack, instr_ready, branch_taken, branch_target
  );

  modport slave (
    input  imem_req, imem_addr, instruction, instr_valid, pc_out, halted,
    output imem_rdata, imem_ack, instr_ready, branch_taken, branch_target
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding memory request, branch redirect, stale-fetch drain.
// Defining FETCH_HALT_EN adds a HALT state entered when a HALT_OPCODE word is handed to decode.
module instr_fetch #(
  parameter int              PC_W        = 8,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter logic [3:0]      HALT_OPCODE = 4'b1111
) (
  input logic           clk,
  input logic           reset,
  instr_fetch_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    FULL,
    DRAIN
`ifdef FETCH_HALT_EN
    , HALT
`endif
  } state_t;

  state_t          state_reg,  state_next;
  logic [PC_W-1:0] pc_reg,     pc_next;
  logic [PC_W-1:0] addr_reg,   addr_next;
  logic [15:0]     instr_reg,  instr_next;
  logic [PC_W-1:0] pc_out_reg, pc_out_next;
  logic            valid_reg,  valid_next;

  logic transfer;
  logic halt_word;

  assign transfer = valid_reg & bus.instr_ready;

`ifdef FETCH_HALT_EN
  assign halt_word = (instr_reg[13:10] == HALT_OPCODE);
`else
  assign halt_word = 1'b0;
  logic unused_halt_cfg;
  assign unused_halt_cfg = ^{HALT_OPCODE, halt_word};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      pc_reg     <= RESET_PC;
      addr_reg   <= RESET_PC;
      instr_reg  <= 16'h0000;
      pc_out_reg <= '0;
      valid_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      addr_reg   <= addr_next;
      instr_reg  <= instr_next;
      pc_out_reg <= pc_out_next;
      valid_reg  <= valid_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    addr_next   = addr_reg;
    instr_next  = instr_reg;
    pc_out_next = pc_out_reg;
    valid_next  = valid_reg;

    case (state_reg)
      IDLE: begin
        state_next = REQ;
        addr_next  = pc_reg;
      end

      REQ: begin
        if (bus.imem_ack) begin
          if (bus.branch_taken) begin
            pc_next    = bus.branch_target;
            addr_next  = bus.branch_target;
            state_next = REQ;
          end else begin
            instr_next  = bus.imem_rdata;
            pc_out_next = pc_reg;
            pc_next     = pc_reg + PC_W'(1);
            valid_next  = 1'b1;
            state_next  = FULL;
          end
        end else if (bus.branch_taken) begin
          // The old request must still complete; its address stays on the bus.
          pc_next    = bus.branch_target;
          state_next = DRAIN;
        end
      end

      DRAIN: begin
        if (bus.branch_taken) begin
          pc_next = bus.branch_target;
        end
        if (bus.imem_ack) begin
          addr_next  = bus.branch_taken ? bus.branch_target : pc_reg;
          state_next = REQ;
        end
      end

      FULL: begin
        if (bus.branch_taken) begin
          valid_next = 1'b0;
          pc_next    = bus.branch_target;
          addr_next  = bus.branch_target;
          state_next = REQ;
        end else if (transfer) begin
          valid_next = 1'b0;
          addr_next  = pc_reg;
`ifdef FETCH_HALT_EN
          state_next = halt_word ? HALT : REQ;
`else
          state_next = REQ;
`endif
        end
      end

`ifdef FETCH_HALT_EN
      HALT: begin
        state_next = HALT;
        valid_next = 1'b0;
      end
`endif

      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
      end
    endcase
  end

  assign bus.imem_req    = (state_reg == REQ) || (state_reg == DRAIN);
  assign bus.imem_addr   = addr_reg;
  assign bus.instruction = instr_reg;
  assign bus.instr_valid = valid_reg;
  assign bus.pc_out      = pc_out_reg;

`ifdef FETCH_HALT_EN
  assign bus.halted = (state_reg == HALT);
`else
  assign bus.halted = 1'b0;
`endif

  addr_stable_a: assert property (@(posedge clk) disable iff (reset)
    (bus.imem_req && !bus.imem_ack) |=> (bus.imem_req && addr_reg == $past(addr_reg)));

  hold_a: assert property (@(posedge clk) disable iff (reset)
    (valid_reg && !bus.instr_ready && !bus.branch_taken) |=>
      (valid_reg && instr_reg == $past(instr_reg) && pc_out_reg == $past(pc_out_reg)));

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: scoreboard of expected requests and deliveries
// plus per-scenario inline checks; bus_b hosts a RESET_PC=8'hFE instance for PC wrap.
module tb_instr_fetch;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int compared = 0;
  int mismatched = 0;
  int delivered = 0;
  bit mem_en = 1'b0;
  int mem_delay = 0;
  int wait_cnt = 0;
  logic [15:0] mem [256];
  logic [7:0]  req_q[$];
  logic [23:0] exp_q[$];
  logic [7:0]  mon_addr;
  logic [23:0] mon_exp;

  instr_fetch_if #(.PC_W(8)) bus_a ();
  instr_fetch_if #(.PC_W(8)) bus_b ();

  instr_fetch #(.PC_W(8), .RESET_PC(8'h00), .HALT_OPCODE(4'b1111)) u_dut (
    .clk(clk), .reset(reset), .bus(bus_a));
  instr_fetch #(.PC_W(8), .RESET_PC(8'hFE), .HALT_OPCODE(4'b1111)) u_wrap (
    .clk(clk), .reset(reset), .bus(bus_b));

  always #5 clk = ~clk;

  // Scoreboard: handshakes are sampled mid-cycle, when inputs for the next edge are settled.
  always @(negedge clk) begin
    if (bus_a.imem_req === 1'b1 && bus_a.imem_ack === 1'b1) begin
      compared++;
      if (req_q.size() == 0) begin
        mismatched++;
        $display("FAIL req_addr: unexpected request addr=%h", bus_a.imem_addr);
      end else begin
        mon_addr = req_q.pop_front();
        if (bus_a.imem_addr !== mon_addr) begin
          mismatched++;
          $display("FAIL req_addr: got %h want %h", bus_a.imem_addr, mon_addr);
        end else $display("request addr=%h", bus_a.imem_addr);
      end
    end
    if (bus_a.instr_valid === 1'b1 && bus_a.instr_ready === 1'b1) begin
      compared++;
      delivered++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL deliver: unexpected pc=%h instr=%h", bus_a.pc_out, bus_a.instruction);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus_a.pc_out !== mon_exp[23:16] || bus_a.instruction !== mon_exp[15:0]) begin
          mismatched++;
          $display("FAIL deliver: got pc=%h instr=%h want pc=%h instr=%h",
                   bus_a.pc_out, bus_a.instruction, mon_exp[23:16], mon_exp[15:0]);
        end else $display("deliver pc=%h instr=%h", bus_a.pc_out, bus_a.instruction);
      end
    end
  end

  // One clock: memory responder for bus_a acts just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    bus_a.branch_taken = 1'b0;
    bus_a.imem_ack     = 1'b0;
    bus_a.imem_rdata   = 'x;
    if (mem_en && bus_a.imem_req === 1'b1) begin
      if (wait_cnt >= mem_delay) begin
        bus_a.imem_ack   = 1'b1;
        bus_a.imem_rdata = mem[bus_a.imem_addr];
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end
  endtask

  task automatic do_reset();
    mem_en = 1'b0;
    bus_a.instr_ready = 1'b0;
    step();
    compared++;
    if (req_q.size() != 0 || exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL queue_drain: pending req=%0d deliver=%0d want 0/0", req_q.size(), exp_q.size());
    end
    reset = 1'b1;
    req_q.delete();
    exp_q.delete();
    wait_cnt = 0;
    mem_delay = 0;
    repeat (2) step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) step();
    compared++;
    if (bus_a.imem_req !== 1'b0 || bus_a.imem_addr !== 8'h00 || bus_a.instruction !== 16'h0000 ||
        bus_a.instr_valid !== 1'b0 || bus_a.pc_out !== 8'h00 || bus_a.halted !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_state: req=%b addr=%h instr=%h valid=%b pc_out=%h halted=%b want 0/00/0000/0/00/0",
               bus_a.imem_req, bus_a.imem_addr, bus_a.instruction, bus_a.instr_valid, bus_a.pc_out, bus_a.halted);
    end
    compared++;
    if (bus_b.imem_addr !== 8'hFE || bus_b.imem_req !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_pc: addr=%h req=%b want FE/0", bus_b.imem_addr, bus_b.imem_req);
    end
    reset = 1'b0;
    mem_en = 1'b1;
    req_q.push_back(8'h00);
    step();
    compared++;
    if (bus_a.imem_req !== 1'b1 || bus_a.imem_addr !== 8'h00) begin
      mismatched++;
      $display("FAIL first_req: req=%b addr=%h want 1/00", bus_a.imem_req, bus_a.imem_addr);
    end
    step();
    reset = 1'b1;
    bus_a.branch_taken  = 1'b1;
    bus_a.branch_target = 8'h55;
    step();
    compared++;
    if (bus_a.instr_valid !== 1'b0 || bus_a.instruction !== 16'h0000 || bus_a.pc_out !== 8'h00 ||
        bus_a.imem_req !== 1'b0 || bus_a.imem_addr !== 8'h00) begin
      mismatched++;
      $display("FAIL reset_full: valid=%b instr=%h pc_out=%h req=%b addr=%h want 0/0000/00/0/00",
               bus_a.instr_valid, bus_a.instruction, bus_a.pc_out, bus_a.imem_req, bus_a.imem_addr);
    end
  endtask

  task automatic test_stream();
    int d0;
    do_reset();
    mem_en = 1'b1;
    bus_a.instr_ready = 1'b1;
    for (int i = 0; i <= 8; i++) req_q.push_back(8'(i));
    for (int i = 0; i < 8; i++) exp_q.push_back({8'(i), 16'h1000 + 16'(i)});
    d0 = delivered;
    repeat (17) step();
    compared++;
    if (delivered - d0 != 8) begin
      mismatched++;
      $display("FAIL throughput: %0d words in 17 cycles want 8", delivered - d0);
    end
    bus_a.instr_ready = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    mem_en = 1'b1;
    req_q.push_back(8'h00);
    repeat (2) step();
    for (int i = 0; i < 5; i++) begin
      compared++;
      if (bus_a.instr_valid !== 1'b1 || bus_a.instruction !== 16'h1000 ||
          bus_a.pc_out !== 8'h00 || bus_a.imem_req !== 1'b0) begin
        mismatched++;
        $display("FAIL stall_hold: cyc=%0d valid=%b instr=%h pc_out=%h req=%b want 1/1000/00/0",
                 i, bus_a.instr_valid, bus_a.instruction, bus_a.pc_out, bus_a.imem_req);
      end
      step();
    end
    bus_a.instr_ready = 1'b1;
    exp_q.push_back({8'h00, 16'h1000});
    req_q.push_back(8'h01);
    step();
    compared++;
    if (bus_a.imem_req !== 1'b1 || bus_a.imem_addr !== 8'h01) begin
      mismatched++;
      $display("FAIL stall_next: req=%b addr=%h want 1/01", bus_a.imem_req, bus_a.imem_addr);
    end
    bus_a.instr_ready = 1'b0;
    step();
    compared++;
    if (bus_a.instr_valid !== 1'b1 || bus_a.pc_out !== 8'h01) begin
      mismatched++;
      $display("FAIL stall_after: valid=%b pc_out=%h want 1/01", bus_a.instr_valid, bus_a.pc_out);
    end
  endtask

  task automatic test_drain();
    do_reset();
    mem_en = 1'b1;
    mem_delay = 3;
    bus_a.instr_ready = 1'b1;
    req_q.push_back(8'h00);
    req_q.push_back(8'h40);
    exp_q.push_back({8'h40, 16'h1040});
    step();
    bus_a.branch_taken  = 1'b1;
    bus_a.branch_target = 8'h40;
    for (int i = 0; i < 3; i++) begin
      step();
      compared++;
      if (bus_a.imem_req !== 1'b1 || bus_a.imem_addr !== 8'h00 || bus_a.instr_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL drain_hold: cyc=%0d req=%b addr=%h valid=%b want 1/00/0",
                 i, bus_a.imem_req, bus_a.imem_addr, bus_a.instr_valid);
      end
    end
    step();
    compared++;
    if (bus_a.imem_req !== 1'b1 || bus_a.imem_addr !== 8'h40 || bus_a.instr_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL drain_redirect: req=%b addr=%h valid=%b want 1/40/0",
               bus_a.imem_req, bus_a.imem_addr, bus_a.instr_valid);
    end
    for (int i = 0; i < 8 && bus_a.instr_valid !== 1'b1; i++) step();
    compared++;
    if (bus_a.instr_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL drain_timeout: valid=%b want 1 within 8 cycles", bus_a.instr_valid);
    end
    step();
  endtask

  task automatic test_branch_full();
    do_reset();
    mem_en = 1'b1;
    req_q.push_back(8'h00);
    repeat (2) step();
    compared++;
    if (bus_a.instr_valid !== 1'b1 || bus_a.instruction !== 16'h1000) begin
      mismatched++;
      $display("FAIL bf_full: valid=%b instr=%h want 1/1000", bus_a.instr_valid, bus_a.instruction);
    end
    bus_a.branch_taken  = 1'b1;
    bus_a.branch_target = 8'h20;
    step();
    compared++;
    if (bus_a.instr_valid !== 1'b0 || bus_a.imem_req !== 1'b1 || bus_a.imem_addr !== 8'h20) begin
      mismatched++;
      $display("FAIL bf_redirect: valid=%b req=%b addr=%h want 0/1/20",
               bus_a.instr_valid, bus_a.imem_req, bus_a.imem_addr);
    end
    req_q.push_back(8'h20);
    bus_a.branch_taken  = 1'b1;
    bus_a.branch_target = 8'h30;
    step();
    compared++;
    if (bus_a.instr_valid !== 1'b0 || bus_a.imem_req !== 1'b1 || bus_a.imem_addr !== 8'h30) begin
      mismatched++;
      $display("FAIL bf_ack_branch: valid=%b req=%b addr=%h want 0/1/30",
               bus_a.instr_valid, bus_a.imem_req, bus_a.imem_addr);
    end
    req_q.push_back(8'h30);
    exp_q.push_back({8'h30, 16'h1030});
    bus_a.instr_ready = 1'b1;
    step();
    compared++;
    if (bus_a.instr_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL bf_target_word: valid=%b want 1", bus_a.instr_valid);
    end
    req_q.push_back(8'h31);
    step();
  endtask

  task automatic test_wrap();
    do_reset();
    bus_b.instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      logic [7:0] e;
      e = 8'hFE + 8'(i);
      step();
      compared++;
      if (bus_b.imem_req !== 1'b1 || bus_b.imem_addr !== e) begin
        mismatched++;
        $display("FAIL wrap_addr: req=%b addr=%h want 1/%h", bus_b.imem_req, bus_b.imem_addr, e);
      end
      bus_b.imem_ack   = 1'b1;
      bus_b.imem_rdata = 16'h1000 + {8'h00, bus_b.imem_addr};
      step();
      bus_b.imem_ack   = 1'b0;
      bus_b.imem_rdata = 'x;
      compared++;
      if (bus_b.instr_valid !== 1'b1 || bus_b.pc_out !== e || bus_b.instruction !== 16'h1000 + 16'(e)) begin
        mismatched++;
        $display("FAIL wrap_word: valid=%b pc_out=%h instr=%h want 1/%h/%h",
                 bus_b.instr_valid, bus_b.pc_out, bus_b.instruction, e, 16'h1000 + 16'(e));
      end else $display("wrap deliver pc=%h instr=%h", bus_b.pc_out, bus_b.instruction);
    end
    bus_b.instr_ready = 1'b0;
  endtask

  task automatic test_halt();
    mem[3] = 16'h3C00;
    do_reset();
    mem_en = 1'b1;
    bus_a.instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back({8'(i), 16'h1000 + 16'(i)});
    exp_q.push_back({8'h03, 16'h3C00});
`ifdef FETCH_HALT_EN
    for (int i = 0; i <= 3; i++) req_q.push_back(8'(i));
    for (int i = 0; i < 8; i++) begin
      step();
      compared++;
      if (bus_a.halted !== 1'b0) begin
        mismatched++;
        $display("FAIL halt_early: cyc=%0d halted=%b want 0", i, bus_a.halted);
      end
    end
    step();
    compared++;
    if (bus_a.halted !== 1'b1 || bus_a.imem_req !== 1'b0 || bus_a.instr_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL halt_enter: halted=%b req=%b valid=%b want 1/0/0",
               bus_a.halted, bus_a.imem_req, bus_a.instr_valid);
    end
    bus_a.branch_taken  = 1'b1;
    bus_a.branch_target = 8'h10;
    for (int i = 0; i < 4; i++) begin
      step();
      compared++;
      if (bus_a.halted !== 1'b1 || bus_a.imem_req !== 1'b0 || bus_a.instr_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL halt_stay: cyc=%0d halted=%b req=%b valid=%b want 1/0/0",
                 i, bus_a.halted, bus_a.imem_req, bus_a.instr_valid);
      end
    end
    do_reset();
    mem_en = 1'b1;
    req_q.push_back(8'h00);
    step();
    compared++;
    if (bus_a.halted !== 1'b0 || bus_a.imem_req !== 1'b1 || bus_a.imem_addr !== 8'h00) begin
      mismatched++;
      $display("FAIL halt_reset: halted=%b req=%b addr=%h want 0/1/00",
               bus_a.halted, bus_a.imem_req, bus_a.imem_addr);
    end
`else
    for (int i = 0; i <= 4; i++) req_q.push_back(8'(i));
    for (int i = 0; i < 9; i++) begin
      step();
      compared++;
      if (bus_a.halted !== 1'b0) begin
        mismatched++;
        $display("FAIL halt_disabled: cyc=%0d halted=%b want 0", i, bus_a.halted);
      end
    end
    compared++;
    if (bus_a.imem_req !== 1'b1 || bus_a.imem_addr !== 8'h04) begin
      mismatched++;
      $display("FAIL halt_passthru: req=%b addr=%h want 1/04", bus_a.imem_req, bus_a.imem_addr);
    end
    bus_a.instr_ready = 1'b0;
`endif
    mem[3] = 16'h1003;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    bus_a.imem_ack = 1'b0; bus_a.imem_rdata = '0; bus_a.instr_ready = 1'b0;
    bus_a.branch_taken = 1'b0; bus_a.branch_target = '0;
    bus_b.imem_ack = 1'b0; bus_b.imem_rdata = '0; bus_b.instr_ready = 1'b0;
    bus_b.branch_taken = 1'b0; bus_b.branch_target = '0;

    test_reset();
    test_stream();
    test_stall();
    test_drain();
    test_branch_full();
    test_wrap();
    test_halt();

    mem_en = 1'b0;
    bus_a.instr_ready = 1'b0;
    repeat (2) step();
    compared++;
    if (req_q.size() != 0 || exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL final_drain: pending req=%0d deliver=%0d want 0/0", req_q.size(), exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
